// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package arbiter_pkg;

  // Widest port count the rotating-priority helper can scan.
  localparam int ARB_MAX_N     = 32;
  localparam int ARB_N_DEFAULT = 4;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [clog2_min1(ARB_N_DEFAULT)-1:0] grant_idx_t;

  // First set bit of valid_mask at or after start, wrapping modulo n; -1 if none.
  function automatic int rr_first(input logic [ARB_MAX_N-1:0] valid_mask,
                                  input int n, input int start);
    int res;
    int pos;
    res = -1;
    pos = 0;
    for (int k = 0; k < ARB_MAX_N; k++) begin
      if (k < n && res < 0 && n > 0) begin
        pos = (start + k) % n;
        if (valid_mask[pos]) res = pos;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/arbiter_wrr_n_rr_prio_pick.sv
// Combinational rotating-priority picker: first set mask bit at or after start.
module rr_prio_pick
  import arbiter_pkg::*;
#(
  parameter int N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [ARB_MAX_N-1:0] w_mask;
  int                   w_pos;

  // Widen the mask for the shared helper and convert its result to an index.
  always_comb begin
    w_mask         = '0;
    w_mask[N-1:0]  = mask;
    w_pos          = rr_first(w_mask, N, int'(start));
    found          = (w_pos >= 0);
    idx            = found ? w_pos[IW-1:0] : '0;
  end

endmodule

// File: rtl/arbiter_wrr_n.sv
// N-input weighted round-robin arbiter with a registered output slice.
// Optional build macro ARB_WRR_STATS_EN adds per-port grant counters and
// the stat_sel / stat_count read port.
module arbiter_wrr_n
  import arbiter_pkg::*;
#(
  parameter int N      = 4,
  parameter int DWIDTH = 16,
  parameter int WW     = 4,
  localparam int IW    = clog2_min1(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      in_valid,
  input  logic [DWIDTH-1:0] in_data [N-1:0],
  output logic [N-1:0]      in_ready,
  input  logic [WW-1:0]     cfg_weight [N-1:0],
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic [IW-1:0]     out_src,
  input  logic              out_ready
`ifdef ARB_WRR_STATS_EN
  ,
  input  logic [IW-1:0]     stat_sel,
  output logic [31:0]       stat_count
`endif
);

  logic [IW-1:0] r_cur;
  logic [WW:0]   r_cnt;

  logic          w_load_en;
  logic          w_keep;
  logic          w_xfer;
  logic [WW:0]   w_eff_cur;
  logic [IW-1:0] w_start;
  logic [IW-1:0] w_scan_idx;
  logic          w_scan_found;
  logic [IW-1:0] w_sel;

  // Scan starts one past the current owner so the owner is considered last.
  rr_prio_pick #(.N(N)) u_pick (
    .mask  (in_valid),
    .start (w_start),
    .idx   (w_scan_idx),
    .found (w_scan_found)
  );

  // Grant selection: stay on the owner while it has budget, else rotate.
  always_comb begin
    w_load_en = !reset && (!out_valid || out_ready);
    w_eff_cur = (cfg_weight[r_cur] == '0) ? (WW+1)'(1) : {1'b0, cfg_weight[r_cur]};
    w_keep    = in_valid[r_cur] && (r_cnt < w_eff_cur);
    w_start   = (r_cur == IW'(N-1)) ? '0 : r_cur + 1'b1;
    w_sel     = w_keep ? r_cur : w_scan_idx;
    w_xfer    = w_load_en && (w_keep || w_scan_found);
    in_ready  = '0;
    if (w_xfer) in_ready[w_sel] = 1'b1;
  end

  // Owner/budget state and the output slice; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      r_cur     <= '0;
      r_cnt     <= '0;
    end else if (w_load_en) begin
      if (w_xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[w_sel];
        out_src   <= w_sel;
        // A re-grant reached by rotation (even onto the same port) starts a new burst.
        if (w_keep) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cur <= w_sel;
          r_cnt <= (WW+1)'(1);
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ARB_WRR_STATS_EN
  logic [31:0] r_stat [N];

  // Per-port grant counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_stat[i] <= '0;
    end else if (w_xfer) begin
      r_stat[w_sel] <= r_stat[w_sel] + 32'd1;
    end
  end

  assign stat_count = (int'(stat_sel) < N) ? r_stat[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_arbiter_wrr_n.sv
// Randomised + directed bench for arbiter_wrr_n against a behavioural model.
module tb_arbiter_wrr_n;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  in_valid = '0;
  logic [N-1:0]  in_ready;
  logic [DW-1:0] in_data [N-1:0];
  logic [WW-1:0] cfg_weight [N-1:0];
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          out_ready = 1'b1;
`ifdef ARB_WRR_STATS_EN
  logic [1:0]    stat_sel = '0;
  logic [31:0]   stat_count;
  int            m_stat [N];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: owning port, beats used in its burst, output slice.
  int           m_cur = 0;
  int           m_cnt = 0;
  bit           m_ov  = 0;
  logic [15:0]  m_od  = '0;
  int           m_os  = 0;

  int           seq [N];
  int           exp_seq [N];
  logic [15:0]  base [N];
  logic [N-1:0] keep_mask = '0;
  bit           rand_vld = 0;
  int           last_xfer = -1;
  int           n_xfer = 0;
  int           obs_src [$];
  logic [15:0]  obs_data [$];

  always #5 clk = ~clk;

  arbiter_wrr_n #(.N(N), .DWIDTH(DW), .WW(WW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .cfg_weight (cfg_weight),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready)
`ifdef ARB_WRR_STATS_EN
    ,
    .stat_sel   (stat_sel),
    .stat_count (stat_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_w(input int a, input int b, input int c, input int d);
    cfg_weight[0] = WW'(a);
    cfg_weight[1] = WW'(b);
    cfg_weight[2] = WW'(c);
    cfg_weight[3] = WW'(d);
  endtask

  // Drive fresh beats: a port that just transferred moves to its next sequence number.
  task automatic refill();
    for (int i = 0; i < N; i++) begin
      if (last_xfer == i) begin
        seq[i]++;
        in_valid[i] = 1'b0;
      end
      in_data[i] = base[i] + 16'(seq[i]);
      if (!in_valid[i])
        in_valid[i] = keep_mask[i] && (!rand_vld || ($urandom_range(0, 1) == 1));
    end
  endtask

  // One clock: check DUT against the model at negedge, advance the model at posedge.
  task automatic step();
    int          sel;
    int          w;
    int          p;
    bit          keep;
    bit          any;
    bit          le;
    bit          xfer;
    logic [15:0] d;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    w    = (cfg_weight[m_cur] == 0) ? 1 : int'(cfg_weight[m_cur]);
    any  = |in_valid;
    keep = in_valid[m_cur] && (m_cnt < w);
    sel  = m_cur;
    if (!keep)
      for (int k = N; k >= 1; k--) begin
        p = (m_cur + k) % N;
        if (in_valid[p]) sel = p;
      end
    le      = !reset && (!m_ov || out_ready);
    xfer    = le && any;
    exp_rdy = xfer ? (N'(1) << sel) : '0;
    d       = in_data[sel];
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_data", 32'(out_data), 32'(m_od));
      chk("out_src", 32'(out_src), 32'(m_os));
    end
    if (out_valid === 1'b1 && out_ready && !reset) begin
      obs_src.push_back(int'(out_src));
      obs_data.push_back(out_data);
      chk("order", 32'(out_data), 32'(base[out_src] + 16'(exp_seq[out_src])));
      exp_seq[out_src]++;
    end
    @(posedge clk);
    if (reset) begin
      m_cur = 0; m_cnt = 0; m_ov = 0; m_od = '0; m_os = 0;
`ifdef ARB_WRR_STATS_EN
      for (int i = 0; i < N; i++) m_stat[i] = 0;
`endif
    end else if (le) begin
      if (xfer) begin
        m_ov  = 1;
        m_od  = d;
        m_os  = sel;
        m_cnt = keep ? m_cnt + 1 : 1;
        m_cur = sel;
        n_xfer++;
`ifdef ARB_WRR_STATS_EN
        m_stat[sel]++;
`endif
      end else begin
        m_ov = 0;
      end
    end
    last_xfer = xfer ? sel : -1;
    #1;
    refill();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) exp_seq[i] = seq[i];
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    obs_src.delete();
    obs_data.delete();
  endtask

  initial begin
    int exp3 [10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
    logic [15:0] held;
    for (int i = 0; i < N; i++) begin
      seq[i]     = 0;
      exp_seq[i] = 0;
      base[i]    = 16'(i << 12);
      in_data[i] = base[i];
    end
    set_w(1, 1, 1, 1);
    @(posedge clk);
    #1;

    // Reset with every port requesting; nothing may be granted.
    keep_mask = 4'hF;
    in_valid  = 4'hF;
    refill();
    do_reset(3);
    step();
    step();
    chk("first_src", 32'(obs_src.size() > 0 ? obs_src[0] : -1), 32'd0);

    // Equal weights: plain rotation, one beat per cycle.
    set_w(1, 1, 1, 1);
    do_reset(1);
    repeat (9) step();
    chk("rr_count", 32'(obs_src.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      if (k < obs_src.size()) chk("rr_src", 32'(obs_src[k]), 32'(k % 4));

    // Mixed weights with a zero weight acting as one.
    set_w(3, 1, 2, 0);
    do_reset(1);
    repeat (11) step();
    chk("wrr_count", 32'(obs_src.size()), 32'd10);
    for (int k = 0; k < 10; k++)
      if (k < obs_src.size()) chk("wrr_src", 32'(obs_src[k]), 32'(exp3[k]));

    // Single active port keeps streaming past its weight without bubbles.
    set_w(1, 1, 2, 1);
    keep_mask = 4'b0100;
    in_valid  = in_valid & keep_mask;
    base[2]   = 16'hA000;
    seq[2]    = 0;
    refill();
    do_reset(1);
    repeat (11) step();
    chk("solo_count", 32'(obs_data.size()), 32'd10);
    for (int k = 0; k < 10; k++)
      if (k < obs_data.size()) begin
        chk("solo_data", 32'(obs_data[k]), 32'(16'hA000 + 16'(k)));
        chk("solo_src", 32'(obs_src[k]), 32'd2);
      end

    // Downstream stall mid-stream: slice holds, nothing granted, no loss afterwards.
    set_w(2, 1, 3, 1);
    keep_mask = 4'hF;
    do_reset(1);
    repeat (6) step();
    out_ready = 1'b0;
    held = out_data;
    repeat (5) begin
      step();
      chk("stall_data", 32'(out_data), 32'(held));
    end
    out_ready = 1'b1;
    repeat (8) step();

`ifdef ARB_WRR_STATS_EN
    // Grant counters after 14 beats of the mixed-weight pattern, then cleared by reset.
    begin
      int exp_stat [4] = '{6, 2, 4, 2};
      set_w(3, 1, 2, 0);
      keep_mask = 4'hF;
      do_reset(1);
      n_xfer = 0;
      for (int g = 0; g < 40 && n_xfer < 14; g++) step();
      chk("stat_beats", 32'(n_xfer), 32'd14);
      keep_mask = '0;
      in_valid  = '0;
      for (int p = 0; p < N; p++) begin
        stat_sel = 2'(p);
        #1;
        chk("stat_count", stat_count, 32'(exp_stat[p]));
        chk("stat_model", stat_count, 32'(m_stat[p]));
      end
      keep_mask = 4'hF;
      refill();
      repeat (3) step();
      do_reset(1);
      for (int p = 0; p < N; p++) begin
        stat_sel = 2'(p);
        #1;
        chk("stat_clear", stat_count, 32'd0);
      end
    end
`endif

    // Random traffic, random backpressure and weights changing mid-burst.
    rand_vld  = 1;
    keep_mask = 4'hF;
    do_reset(1);
    for (int c = 0; c < 800; c++) begin
      if (c % 25 == 0)
        set_w($urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
